// File: rtl/pr_emif_burst_master.sv
// Burst-splitting Avalon-MM master feeding the PR-to-EMIF bridge (512-bit, 25-bit word address).
// Define PR_EMIF_BURST_MASTER_STATS_EN to build the saturating beat/stall statistics counters.
module pr_emif_burst_master #(
  parameter int unsigned MAX_BURST         = 64,
  parameter int unsigned MAX_PENDING_READS = 256
) (
  input  logic         pr_region_clk,
  input  logic         pr_region_reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [24:0]  cmd_address,
  input  logic [15:0]  cmd_length,
  output logic         done,
  input  logic [511:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [511:0] rd_data,
  output logic         rd_valid,
  output logic [24:0]  avm_address,
  output logic [6:0]   avm_burstcount,
  output logic         avm_read,
  output logic         avm_write,
  output logic [511:0] avm_writedata,
  output logic [63:0]  avm_byteenable,
  output logic         avm_debugaccess,
  input  logic         avm_waitrequest,
  input  logic [511:0] avm_readdata,
  input  logic         avm_readdatavalid,
  output logic [31:0]  stat_rd_beats,
  output logic [31:0]  stat_wr_beats,
  output logic [31:0]  stat_stall_cycles
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_REQ   = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_WR_BURST = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam int unsigned PW  = $clog2(MAX_PENDING_READS + MAX_BURST + 1);
  localparam int unsigned PW1 = PW + 1;
  localparam logic [7:0]  OFF_MASK = 8'(MAX_BURST - 1);

  logic [2:0]    r_state;
  logic [24:0]   r_addr;
  logic [15:0]   r_remaining;
  logic [PW-1:0] r_pending;
  logic [6:0]    r_beat;
  logic          r_gap;
  logic          r_rd_valid;
  logic [511:0]  r_rd_data;

  logic [7:0]    w_offset;
  logic [7:0]    w_room;
  logic [6:0]    w_burst_len;
  logic          w_last_burst;
  logic [PW:0]   w_pend_sum;
  logic          w_pend_ok;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_wr_burst_end;
  logic          w_ret;
  logic [PW-1:0] w_pending_next;
  logic          w_bus_state;

  always_comb begin
    w_offset    = r_addr[7:0] & OFF_MASK;
    w_room      = 8'(MAX_BURST) - w_offset;
    w_burst_len = (r_remaining < 16'(w_room)) ? r_remaining[6:0] : w_room[6:0];
    w_last_burst = (r_remaining == 16'(w_burst_len));
    w_pend_sum  = {1'b0, r_pending} + PW1'(w_burst_len);
    w_pend_ok   = (w_pend_sum <= PW1'(MAX_PENDING_READS));
    w_bus_state = (r_state == S_RD_REQ) || (r_state == S_WR_BURST);
  end

  // r_gap idles the read request for one cycle after each acceptance so the
  // pending check always sees the updated count.
  assign avm_read       = (r_state == S_RD_REQ) && !r_gap && w_pend_ok;
  assign avm_write      = (r_state == S_WR_BURST) && wr_valid;
  assign wr_ready       = (r_state == S_WR_BURST) && !avm_waitrequest;
  assign avm_address    = w_bus_state ? r_addr : '0;
  assign avm_burstcount = w_bus_state ? w_burst_len : '0;
  assign avm_writedata  = wr_data;
  assign avm_byteenable = '1;
  assign avm_debugaccess = 1'b0;

  assign w_rd_acc       = avm_read && !avm_waitrequest;
  assign w_wr_acc       = avm_write && !avm_waitrequest;
  assign w_wr_burst_end = w_wr_acc && (r_beat == w_burst_len - 7'd1);
  assign w_ret          = avm_readdatavalid && (r_pending != '0);
  assign w_pending_next = r_pending + (w_rd_acc ? PW'(w_burst_len) : '0) - PW'(w_ret);

  assign cmd_ready = (r_state == S_IDLE) && !pr_region_reset;
  assign done      = (r_state == S_DONE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  always_ff @(posedge pr_region_clk) begin
    if (pr_region_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_pending   <= '0;
      r_beat      <= '0;
      r_gap       <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_pending  <= w_pending_next;
      r_rd_valid <= w_ret;
      if (w_ret) r_rd_data <= avm_readdata;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_address;
            r_remaining <= cmd_length;
            r_beat      <= '0;
            r_gap       <= 1'b0;
            if (cmd_length == '0)  r_state <= S_DONE;
            else if (cmd_write)    r_state <= S_WR_BURST;
            else                   r_state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          r_gap <= w_rd_acc;
          if (w_rd_acc) begin
            r_addr      <= r_addr + 25'(w_burst_len);
            r_remaining <= r_remaining - 16'(w_burst_len);
            if (w_last_burst) r_state <= S_RD_DRAIN;
          end
        end
        S_RD_DRAIN: begin
          if (w_pending_next == '0) r_state <= S_DONE;
        end
        S_WR_BURST: begin
          if (w_wr_burst_end) begin
            r_beat      <= '0;
            r_addr      <= r_addr + 25'(w_burst_len);
            r_remaining <= r_remaining - 16'(w_burst_len);
            if (w_last_burst) r_state <= S_DONE;
          end else if (w_wr_acc) begin
            r_beat <= r_beat + 7'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PR_EMIF_BURST_MASTER_STATS_EN
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_stall;

  always_ff @(posedge pr_region_clk) begin
    if (pr_region_reset) begin
      r_stat_rd    <= '0;
      r_stat_wr    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_rd_valid && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 32'd1;
      if (w_wr_acc && (r_stat_wr != '1))   r_stat_wr <= r_stat_wr + 32'd1;
      if ((avm_read || avm_write) && avm_waitrequest && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_rd_beats     = r_stat_rd;
  assign stat_wr_beats     = r_stat_wr;
  assign stat_stall_cycles = r_stat_stall;
`else
  assign stat_rd_beats     = '0;
  assign stat_wr_beats     = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule
